// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and issue controller for a Decode -> Execute -> WriteBack pipeline.
//   A scoreboard (busy_mask) tracks destination registers still in flight.
//   Decode is stalled while its instruction reads or rewrites a busy register.
//   After reset, and after a watchdog fault, internal_reset is held to flush
//   the EX/WB pipeline registers.
//
//   Optional feature, macro WB_BYPASS_EN:
//     defined   - a register being committed by WriteBack this cycle is not
//                 treated as busy, so a dependent instruction issues in the
//                 commit cycle (write-through register file).
//     undefined - hazards use the registered scoreboard only, so a dependent
//                 instruction issues the cycle after the commit.
//
//   Ports
//     clock, reset_n          rising-edge clock, asynchronous active-low reset
//     id_valid                Decode holds a valid instruction
//     id_src_a/_used          source A address / source A is read
//     id_src_b/_used          source B address / source B is read
//     id_dst/id_dst_wr        destination address / instruction writes it
//     wb_wr_en/wb_dst         WriteBack commits register wb_dst this cycle
//     stalled                 Decode must hold its instruction
//     issue                   instruction accepted into EX this cycle
//     internal_reset          flush for EX/WB pipeline registers
//     busy_mask               scoreboard, bit i = write to reg i pending
//     stall_cnt               saturating total count of stall cycles
//     stall_timeout           sticky watchdog flag
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int RESET_HOLD = 4,
  parameter int STALL_MAX  = 15,
  parameter int CNT_W      = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       id_valid,
  input  logic [REG_ADDR_W-1:0]      id_src_a,
  input  logic                       id_src_a_used,
  input  logic [REG_ADDR_W-1:0]      id_src_b,
  input  logic                       id_src_b_used,
  input  logic [REG_ADDR_W-1:0]      id_dst,
  input  logic                       id_dst_wr,
  input  logic                       wb_wr_en,
  input  logic [REG_ADDR_W-1:0]      wb_dst,
  output logic                       stalled,
  output logic                       issue,
  output logic                       internal_reset,
  output logic [2**REG_ADDR_W-1:0]   busy_mask,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic                       stall_timeout
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int HOLD_W   = $clog2(RESET_HOLD + 1);
  localparam int RUN_W    = $clog2(STALL_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(STALL_MAX - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_REGS-1:0]   wb_mask;
  logic [NUM_REGS-1:0]   dst_mask;
  logic [NUM_REGS-1:0]   busy_eff;
  logic                  hazard;
  logic                  in_pipe;

  // One-hot decode of the committing and the destination register.
  always_comb begin
    wb_mask  = '0;
    dst_mask = '0;
    if (wb_wr_en) wb_mask[wb_dst] = 1'b1;
    dst_mask[id_dst] = 1'b1;
  end

  // Scoreboard view used for the hazard check.
  always_comb begin
`ifdef WB_BYPASS_EN
    // Register being written back this cycle is readable through the RF.
    busy_eff = busy_q & ~wb_mask;
`else
    busy_eff = busy_q;
`endif
  end

  always_comb begin
    hazard = id_valid & ((id_src_a_used & busy_eff[id_src_a]) |
                         (id_src_b_used & busy_eff[id_src_b]) |
                         (id_dst_wr     & busy_eff[id_dst]));
  end

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    stalled        = 1'b1;
    issue          = 1'b0;
    internal_reset = 1'b1;
    in_pipe        = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        internal_reset = 1'b0;
        in_pipe        = 1'b1;
        stalled        = hazard;
        issue          = id_valid & ~hazard;
        // Watchdog fires on the STALL_MAX-th consecutive stalled cycle.
        if (hazard && (run_q == RUN_LAST)) state_d = S_FAULT;
        else if (hazard)                   state_d = S_STALL;
        else                               state_d = S_RUN;
      end
      S_FAULT: begin
        state_d = S_INIT;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Counter, scoreboard and flag next values.
  always_comb begin
    hold_d      = '0;
    run_d       = '0;
    busy_d      = '0;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q | (state_d == S_FAULT);
    if (state_q == S_INIT) hold_d = hold_q + 1'b1;
    if (in_pipe) begin
      // Set after clear: a same-cycle issue to the committing register wins.
      busy_d = busy_q & ~wb_mask;
      if (issue && id_dst_wr) busy_d = busy_d | dst_mask;
      if (stalled) begin
        if (state_d != S_FAULT) run_d = run_q + 1'b1;
        if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      hold_q      <= '0;
      run_q       <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy_mask     = busy_q;
  assign stall_cnt     = stall_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (default parameters).
//   Directed table of single-cycle vectors, hand sequences for reset hold,
//   watchdog fault, async reset and counter saturation, then random traffic
//   compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RESET_HOLD = 4;
  localparam int STALL_MAX  = 15;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       id_valid, id_src_a_used, id_src_b_used, id_dst_wr, wb_wr_en;
  logic [2:0] id_src_a, id_src_b, id_dst, wb_dst;
  logic       stalled, issue, internal_reset, stall_timeout;
  logic [7:0] busy_mask, stall_cnt;

  pipe_hazard_ctrl dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_a_used(id_src_a_used),
    .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
    .id_dst(id_dst), .id_dst_wr(id_dst_wr),
    .wb_wr_en(wb_wr_en), .wb_dst(wb_dst),
    .stalled(stalled), .issue(issue), .internal_reset(internal_reset),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_init;    // cycles of reset hold remaining (0 = not holding)
  bit         m_fault;   // in the one-cycle fault slot
  logic [7:0] m_busy;
  int         m_run;     // consecutive stalled cycles
  int         m_total;   // total stalled cycles (saturating)
  bit         m_to;

  task automatic model_reset();
    m_init = RESET_HOLD; m_fault = 0; m_busy = '0;
    m_run = 0; m_total = 0; m_to = 0;
  endtask

  task automatic model_comb(output bit st, output bit iss, output bit ir);
    logic [7:0] eff;
    bit hz;
    if (m_fault || m_init > 0) begin
      st = 1; iss = 0; ir = 1;
    end else begin
      eff = m_busy;
      if (BYP && wb_wr_en) eff[wb_dst] = 1'b0;
      hz = id_valid && ((id_src_a_used && eff[id_src_a]) ||
                        (id_src_b_used && eff[id_src_b]) ||
                        (id_dst_wr && eff[id_dst]));
      st = hz; iss = id_valid && !hz; ir = 0;
    end
  endtask

  task automatic model_step();
    bit st, iss, ir;
    model_comb(st, iss, ir);
    if (m_fault) begin
      m_fault = 0; m_init = RESET_HOLD; m_busy = '0; m_run = 0;
    end else if (m_init > 0) begin
      m_init--; m_busy = '0;
    end else begin
      if (wb_wr_en) m_busy[wb_dst] = 1'b0;
      if (iss && id_dst_wr) m_busy[id_dst] = 1'b1;
      if (st) begin
        if (m_total < 255) m_total++;
        m_run++;
        if (m_run == STALL_MAX) begin
          m_fault = 1; m_to = 1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic model_check();
    bit st, iss, ir;
    model_comb(st, iss, ir);
    check("stalled", stalled, st);
    check("issue", issue, iss);
    check("internal_reset", internal_reset, ir);
    check("busy_mask", busy_mask, m_busy);
    check("stall_cnt", stall_cnt, m_total);
    check("stall_timeout", stall_timeout, m_to);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    model_check();
    @(posedge clock);
    if (reset_n) model_step();
    @(negedge clock);
  endtask

  task automatic set_in(input logic v, input logic [2:0] sa, input logic au,
                        input logic [2:0] sb, input logic bu, input logic [2:0] d,
                        input logic dw, input logic we, input logic [2:0] wd);
    id_valid = v; id_src_a = sa; id_src_a_used = au; id_src_b = sb;
    id_src_b_used = bu; id_dst = d; id_dst_wr = dw; wb_wr_en = we; wb_dst = wd;
  endtask

  task automatic set_idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic v; logic [2:0] sa; logic au; logic [2:0] sb; logic bu;
    logic [2:0] d; logic dw; logic we; logic [2:0] wd;
    logic st; logic is; logic [7:0] bm;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    //            v    sa   au   sb   bu   d    dw   we   wd   st    is   bm
    tbl[0]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd3,1'b1,1'b0,3'd0,1'b0,1'b1,8'h00};
    tbl[1]  = '{1'b1,3'd3,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b1,1'b0,8'h08};
    tbl[2]  = '{1'b1,3'd3,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b1,1'b0,8'h08};
    tbl[3]  = '{1'b1,3'd3,1'b1,3'd0,1'b0,3'd0,1'b0,1'b1,3'd3,!BYP, BYP,8'h08};
    tbl[4]  = '{1'b1,3'd3,1'b1,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b1,8'h00};
    tbl[5]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd5,1'b1,1'b0,3'd0,1'b0,1'b1,8'h00};
    tbl[6]  = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd5,1'b1,1'b1,3'd5,!BYP, BYP,8'h20};
    tbl[7]  = '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,BYP ? 8'h20 : 8'h00};
    tbl[8]  = '{1'b1,3'd0,1'b0,3'd5,1'b1,3'd0,1'b0,1'b0,3'd0, BYP,!BYP,BYP ? 8'h20 : 8'h00};
    tbl[9]  = '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b1,3'd5,1'b0,1'b0,BYP ? 8'h20 : 8'h00};
    tbl[10] = '{1'b1,3'd0,1'b0,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0,1'b1,8'h00};
    tbl[11] = '{1'b1,3'd1,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b1,1'b0,8'h40};
    tbl[12] = '{1'b0,3'd6,1'b1,3'd0,1'b0,3'd6,1'b1,1'b0,3'd0,1'b0,1'b0,8'h40};
    tbl[13] = '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b1,3'd6,1'b0,1'b0,8'h40};
    tbl[14] = '{1'b0,3'd0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,3'd0,1'b0,1'b0,8'h00};

    // Power-on reset.
    reset_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clock);
    tick();
    tick();
    reset_n = 1'b1;

    // Reset hold length after release.
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (internal_reset) n++;
      tick();
    end
    check("reset_hold_cycles", n, RESET_HOLD);
    #1;
    check("run_stalled", stalled, 1'b0);
    check("run_busy", busy_mask, 8'h00);

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].v, tbl[i].sa, tbl[i].au, tbl[i].sb, tbl[i].bu,
             tbl[i].d, tbl[i].dw, tbl[i].we, tbl[i].wd);
      #1;
      check($sformatf("tbl%0d_stalled", i), stalled, tbl[i].st);
      check($sformatf("tbl%0d_issue", i), issue, tbl[i].is);
      check($sformatf("tbl%0d_busy", i), busy_mask, tbl[i].bm);
      tick();
    end

    // Watchdog: hazard held with no commit.
    reset_n = 1'b0;
    set_idle();
    model_reset();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < RESET_HOLD; i++) tick();
    set_in(1, 0, 0, 0, 0, 3'd2, 1, 0, 0);
    tick();
    set_in(1, 3'd2, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < STALL_MAX; i++) tick();
    #1;
    check("fault_timeout", stall_timeout, 1'b1);
    check("fault_ireset", internal_reset, 1'b1);
    check("fault_stall_cnt", stall_cnt, 8'd15);
    set_idle();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (internal_reset) n++;
      tick();
    end
    check("fault_ireset_cycles", n, 1 + RESET_HOLD);
    check("fault_busy_cleared", busy_mask, 8'h00);

    // Asynchronous reset in the middle of a stall.
    set_in(1, 0, 0, 0, 0, 3'd2, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 3'd5, 1, 0, 0);
    tick();
    set_in(1, 3'd5, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    #1;
    check("pre_reset_busy", busy_mask, 8'h24);
    check("pre_reset_stalled", stalled, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_ireset", internal_reset, 1'b1);
    check("async_busy", busy_mask, 8'h00);
    check("async_stall_cnt", stall_cnt, 8'h00);
    check("async_timeout", stall_timeout, 1'b0);
    check("async_issue", issue, 1'b0);
    model_reset();
    @(negedge clock);
    tick();
    reset_n = 1'b1;

    // Repeated watchdog rounds drive stall_cnt into saturation.
    set_in(1, 3'd2, 1, 0, 0, 3'd2, 1, 0, 0);
    for (int i = 0; i < 400; i++) tick();
    #1;
    check("sat_stall_cnt", stall_cnt, 8'd255);
    check("sat_timeout", stall_timeout, 1'b1);

    // Random traffic against the model.
    reset_n = 1'b0;
    set_idle();
    model_reset();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        model_reset();
        tick();
        reset_n = 1'b1;
      end
      set_in($urandom_range(0, 9) < 7, 3'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 4, 3'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
